// File: rtl/sr_pattern_driver_pkg.sv
// Shared definitions for the SR flip-flop pattern driver: FSM states and
// S/R excitation codes, plus the excitation-table helper.
package sr_pattern_driver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FFRST = 2'd1,
      ST_DRIVE = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   // {s,r} excitation codes. SR_ILLEGAL is only ever used by checkers.
   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RST     = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   localparam logic [1:0] SR_ILLEGAL = 2'b11;

   // SR excitation table with don't-cares resolved to hold.
   function automatic logic [1:0] sr_code(input logic prev, input logic next_bit);
      if (prev == next_bit) return SR_HOLD;
      else if (next_bit)    return SR_SET;
      else                  return SR_RST;
   endfunction

endpackage

// File: rtl/sr_pattern_driver_excite.sv
// Combinational SR excitation: the S/R pair that moves q from prev to next.
module sr_excite
   import sr_pattern_driver_pkg::*;
(
   input  logic prev,
   input  logic next,
   output logic s,
   output logic r
);

   // Look up the excitation code for this transition.
   // NOTE: every output of an always_comb gets a value on every path, else a latch is inferred.
   always_comb begin
      {s, r} = sr_code(prev, next);
   end

endmodule

// File: rtl/sr_pattern_driver.sv
// Drives an external SR flip-flop through a requested bit pattern, then
// scores its q/qb outputs with a two-edge lag and reports pass/fail.
module sr_pattern_driver
   import sr_pattern_driver_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [WIDTH-1:0] pat_data,
   output logic             ff_s,
   output logic             ff_r,
   output logic             ff_rst,
   input  logic             ff_q,
   input  logic             ff_qb,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] first_err_idx
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_shift;        // remaining bits, next one in bit 0
   logic [CNT_W-1:0]   r_bits_left;
   logic               r_prev;         // q value the flip-flop will hold
   logic               r_drain;
   logic               r_ready;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic               r_ff_s;
   logic               r_ff_r;
   logic               r_ff_rst;
   logic               r_exp1;
   logic               r_v1;
   logic               r_exp2;
   logic               r_v2;
   logic [CNT_W-1:0]   r_err_cnt;
   logic [CNT_W-1:0]   r_first_err;
   logic [CNT_W-1:0]   r_cmp_idx;

   logic               w_s;
   logic               w_r;
   logic               w_accept;
   logic               w_bit_fail;

   assign w_accept   = (r_state == ST_IDLE) && pat_valid;
   assign w_bit_fail = (ff_q != r_exp2) || (ff_qb == ff_q);

   sr_excite u_excite (
      .prev (r_prev),
      .next (r_shift[0]),
      .s    (w_s),
      .r    (w_r)
   );

   // Run sequencer: accepts a pattern, resets the flip-flop, drives one
   // excitation per bit, drains the compare pipeline and signals done.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_bits_left <= '0;
         r_prev      <= 1'b0;
         r_drain     <= 1'b0;
         r_ready     <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_ff_s      <= 1'b0;
         r_ff_r      <= 1'b0;
         r_ff_rst    <= 1'b0;
         r_exp1      <= 1'b0;
         r_v1        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_v1   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (pat_valid) begin
                  r_shift     <= pat_data;
                  r_bits_left <= CNT_W'(WIDTH);
                  r_prev      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_ff_rst    <= 1'b1;
                  r_ff_s      <= 1'b0;
                  r_ff_r      <= 1'b0;
                  r_ready     <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_FFRST;
               end
            end
            // FFRST drives bit 0 against the freshly reset q=0; DRIVE does the rest.
            ST_FFRST, ST_DRIVE: begin
               r_ff_rst <= 1'b0;
               if (r_bits_left == '0) begin
                  r_ff_s  <= 1'b0;
                  r_ff_r  <= 1'b0;
                  r_drain <= 1'b0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_ff_s      <= w_s;
                  r_ff_r      <= w_r;
                  r_prev      <= r_shift[0];
                  r_exp1      <= r_shift[0];
                  r_v1        <= 1'b1;
                  r_shift     <= r_shift >> 1;
                  r_bits_left <= r_bits_left - 1'b1;
                  r_state     <= ST_DRIVE;
               end
            end
            ST_DRAIN: begin
               if (r_drain) begin
                  r_done  <= 1'b1;
                  r_pass  <= (r_err_cnt == '0);
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Second delay stage and scoring: compares q/qb two edges after each
   // bit was driven, counting failures and latching the first one.
   // NOTE: every register here is cleared by reset so an aborted run leaves no stale score.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp2      <= 1'b0;
         r_v2        <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
         r_cmp_idx   <= '0;
      end else begin
         r_exp2 <= r_exp1;
         r_v2   <= r_v1;
         if (w_accept) begin
            r_err_cnt   <= '0;
            r_first_err <= '0;
            r_cmp_idx   <= '0;
         end else if (r_v2) begin
            if (w_bit_fail) begin
               if (r_err_cnt == '0) r_first_err <= r_cmp_idx;
               r_err_cnt <= r_err_cnt + 1'b1;
            end
            r_cmp_idx <= r_cmp_idx + 1'b1;
         end
      end
   end

   assign pat_ready     = r_ready;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_pass;
   assign ff_s          = r_ff_s;
   assign ff_r          = r_ff_r;
   assign ff_rst        = r_ff_rst;
   assign err_cnt       = r_err_cnt;
   assign first_err_idx = r_first_err;

endmodule

// File: tb/tb_sr_pattern_driver.sv
// Self-checking bench: behavioural SR flip-flop with fault injection,
// directed patterns, reset abort and randomized runs against a reference model.
module tb_sr_pattern_driver;
   import sr_pattern_driver_pkg::*;

   localparam int W   = 8;
   localparam int CW  = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          pat_valid;
   logic          pat_ready;
   logic [W-1:0]  pat_data;
   logic          ff_s, ff_r, ff_rst;
   logic          ff_q, ff_qb;
   logic          busy, done, pass;
   logic [CW-1:0] err_cnt, first_err_idx;

   int n_checks = 0;
   int n_errors = 0;
   int fault_mode = 0;   // 0 healthy, 1 q stuck at 0, 2 qb tied to q
   logic model_q = 1'b0;
   logic illegal_seen = 1'b0;

   always #5 clk = ~clk;

   sr_pattern_driver #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst           (rst),
      .pat_valid     (pat_valid),
      .pat_ready     (pat_ready),
      .pat_data      (pat_data),
      .ff_s          (ff_s),
      .ff_r          (ff_r),
      .ff_rst        (ff_rst),
      .ff_q          (ff_q),
      .ff_qb         (ff_qb),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx)
   );

   // Behavioural SR flip-flop with synchronous reset.
   always @(posedge clk) begin
      if (ff_rst)                  model_q <= 1'b0;
      else if (ff_s && !ff_r)      model_q <= 1'b1;
      else if (ff_r && !ff_s)      model_q <= 1'b0;
      else if (ff_s && ff_r)       model_q <= 1'bx;
   end

   assign ff_q  = (fault_mode == 1) ? 1'b0 : model_q;
   assign ff_qb = (fault_mode == 2) ? ff_q : ~model_q;

   // Watch for the forbidden S=R=1 excitation over the whole run.
   always @(negedge clk) begin
      if ({ff_s, ff_r} === SR_ILLEGAL) illegal_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference excitation for bit i: the S/R needed to move q from the
   // previously requested bit (0 before bit 0) to the requested bit.
   function automatic logic [1:0] ref_sr(input logic [W-1:0] p, input int i);
      logic prev_bit, want;
      prev_bit = (i == 0) ? 1'b0 : p[i-1];
      want     = p[i];
      if (want == prev_bit) return 2'b00;
      return want ? 2'b10 : 2'b01;
   endfunction

   // Reference score: a healthy flip-flop's q equals the requested bit,
   // then the fault mode distorts what is observed.
   task automatic ref_score(input logic [W-1:0] p, input int mode,
                            output int errs, output int first);
      logic oq, oqb;
      errs  = 0;
      first = 0;
      for (int i = 0; i < W; i++) begin
         oq  = (mode == 1) ? 1'b0 : p[i];
         oqb = (mode == 2) ? oq : ~p[i];
         if (oq != p[i] || oqb == oq) begin
            if (errs == 0) first = i;
            errs++;
         end
      end
   endtask

   task automatic run_pattern(input string label, input logic [W-1:0] p,
                              input int mode, input bit hold_valid);
      int  cyc;
      int  exp_errs, exp_first;
      bit  early_done;
      fault_mode = mode;
      pat_data   = p;
      pat_valid  = 1'b1;
      cyc = 0;
      while (pat_ready !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check({label, "_ready_wait"}, 32'(cyc < 50), 32'd1);
      @(posedge clk); #1;
      check({label, "_ffrst"}, 32'(ff_rst), 32'd1);
      check({label, "_busy"}, 32'(busy), 32'd1);
      if (!hold_valid) pat_valid = 1'b0;
      early_done = 1'b0;
      for (int k = 1; k <= W + 3; k++) begin
         @(posedge clk); #1;
         if (k <= W)
            check($sformatf("%s_sr%0d", label, k - 1), 32'({ff_s, ff_r}), 32'(ref_sr(p, k - 1)));
         if (k == W + 1)
            check({label, "_sr_idle"}, 32'({ff_s, ff_r}), 32'd0);
         if (k < W + 3 && done) early_done = 1'b1;
      end
      ref_score(p, mode, exp_errs, exp_first);
      check({label, "_early_done"}, 32'(early_done), 32'd0);
      check({label, "_done"}, 32'(done), 32'd1);
      check({label, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
      check({label, "_first_err"}, 32'(first_err_idx), 32'(exp_first));
      check({label, "_pass"}, 32'(pass), 32'(exp_errs == 0));
      check({label, "_ready"}, 32'(pat_ready), 32'd1);
   endtask

   initial begin
      int  gap;
      bit  done_seen;
      rst       = 1'b1;
      pat_valid = 1'b0;
      pat_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(pat_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sr", 32'({ff_s, ff_r, ff_rst}), 32'd0);
      check("rst_done_pass", 32'({done, pass}), 32'd0);
      check("rst_err", 32'(err_cnt), 32'd0);
      check("rst_first", 32'(first_err_idx), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_pattern("a5", 8'hA5, 0, 1'b0);
      run_pattern("z00", 8'h00, 0, 1'b0);
      run_pattern("ff", 8'hFF, 0, 1'b1);
      run_pattern("b2b00", 8'h00, 0, 1'b0);
      run_pattern("qstuck", 8'h0F, 1, 1'b0);
      run_pattern("qbtied", 8'h3C, 2, 1'b0);

      // Abort a run with reset at the edge that would drive bit 3.
      fault_mode = 0;
      @(negedge clk);
      pat_data  = 8'hC3;
      pat_valid = 1'b1;
      @(posedge clk); #1;
      pat_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(pat_ready), 32'd1);
      check("abort_sr", 32'({ff_s, ff_r}), 32'd0);
      check("abort_err", 32'(err_cnt), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      rst = 1'b0;
      done_seen = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (done) done_seen = 1'b1;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      run_pattern("after_abort", 8'h81, 0, 1'b0);

      // Randomized patterns and fault modes with random idle gaps.
      for (int n = 0; n < 24; n++) begin
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         run_pattern($sformatf("rnd%0d", n), W'($urandom), int'($urandom_range(0, 2)), 1'b0);
      end

      check("never_sr11", 32'(illegal_seen), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
